// File: rtl/gift_ctrl_pkg.sv
// Shared types and constants for the GIFT round controller.
package gift_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KEYFWD,
        RUN,
        DONE,
        HOLD
    } ctrlState_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int GIFT64_ROUNDS  = 28;
    localparam int GIFT128_ROUNDS = 40;

endpackage

// File: rtl/gift_iter_counter.sv
// Iteration counter with clear/enable and a terminal flag at LAST.
// Shared by the key-forward and round phases of the controller.
module gift_iter_counter #(
    parameter int CNT_W = 8,
    parameter int LAST  = 39
) (
    input  logic             inClk,
    input  logic             inRstN,
    input  logic             inClr,
    input  logic             inEn,
    output logic [CNT_W-1:0] outCnt,
    output logic             outTerm
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            outCnt <= '0;
        end else if (inClr) begin
            outCnt <= '0;
        end else if (inEn) begin
            outCnt <= outCnt + 1'b1;
        end
    end

    assign outTerm = (outCnt == CNT_W'(LAST));

endmodule

// File: rtl/gift_round_control.sv
// Control FSM for an iterative GIFT encrypt/decrypt datapath (UNROLL rounds/clock).
// Optional abort input enabled by defining GIFT_ROUND_CONTROL_ABORT_EN.
module gift_round_control
    import gift_ctrl_pkg::*;
#(
    parameter int ROUNDS = GIFT128_ROUNDS,
    parameter int UNROLL = 1,
    parameter int CNT_W  = 8
) (
    input  logic             inClk,
    input  logic             inRstN,
`ifdef GIFT_ROUND_CONTROL_ABORT_EN
    input  logic             inAbort,
`endif
    input  logic             inExtKeyWr,
    input  logic             inExtDataWr,
    input  logic             inMode,
    input  logic             inOutReady,
    output logic             outIntKeyschRegExtWr,
    output logic             outIntKeyschRegIntWr,
    output logic             outKeyschDir,
    output logic             outIntRoundRegExtWr,
    output logic             outIntRoundRegIntWr,
    output logic             outIntDataOutRegWr,
    output logic [CNT_W-1:0] outRoundIdx,
    output logic             outModeLatched,
    output logic             outBusy,
    output logic             outValid
);

    localparam int N = ROUNDS / UNROLL;

    if (ROUNDS % UNROLL != 0) begin : gBadUnroll
        $error("gift_round_control: ROUNDS must be a multiple of UNROLL");
    end
    if ((2 ** CNT_W) <= ROUNDS) begin : gBadCntW
        $error("gift_round_control: CNT_W too narrow for ROUNDS");
    end

    ctrlState_e       state, nextState;
    logic [CNT_W-1:0] cnt;
    logic             cntTerm, cntClr, cntEn, modeLoad;
    logic             abortReq, keyReq, dataReq;

`ifdef GIFT_ROUND_CONTROL_ABORT_EN
    assign abortReq = inAbort;
`else
    assign abortReq = 1'b0;
`endif

    // Load requests are masked during reset so no strobe leaks out combinationally.
    assign keyReq  = inExtKeyWr  & inRstN;
    assign dataReq = inExtDataWr & inRstN;

    gift_iter_counter #(
        .CNT_W (CNT_W),
        .LAST  (N - 1)
    ) uIterCnt (
        .inClk   (inClk),
        .inRstN  (inRstN),
        .inClr   (cntClr),
        .inEn    (cntEn),
        .outCnt  (cnt),
        .outTerm (cntTerm)
    );

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            state          <= IDLE;
            outModeLatched <= MODE_ENC;
        end else begin
            state <= nextState;
            if (modeLoad) outModeLatched <= inMode;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        nextState            = state;
        cntClr               = 1'b0;
        cntEn                = 1'b0;
        modeLoad             = 1'b0;
        outIntKeyschRegExtWr = 1'b0;
        outIntKeyschRegIntWr = 1'b0;
        outKeyschDir         = 1'b0;
        outIntRoundRegExtWr  = 1'b0;
        outIntRoundRegIntWr  = 1'b0;
        outIntDataOutRegWr   = 1'b0;
        outRoundIdx          = '0;
        outBusy              = 1'b0;
        outValid             = 1'b0;

        unique case (state)
            IDLE: begin
                outIntKeyschRegExtWr = keyReq;
                outIntRoundRegExtWr  = dataReq;
                if (dataReq) begin
                    cntClr    = 1'b1;
                    modeLoad  = 1'b1;
                    nextState = (inMode == MODE_DEC) ? KEYFWD : RUN;
                end
            end
            KEYFWD: begin
                outBusy              = 1'b1;
                outIntKeyschRegIntWr = 1'b1;
                cntEn                = 1'b1;
                if (cntTerm) begin
                    cntClr    = 1'b1;
                    nextState = RUN;
                end
            end
            RUN: begin
                outBusy              = 1'b1;
                outIntRoundRegIntWr  = 1'b1;
                outIntKeyschRegIntWr = 1'b1;
                outKeyschDir         = outModeLatched;
                cntEn                = 1'b1;
                // Decryption consumes round constants from the last round downwards.
                if (outModeLatched == MODE_DEC)
                    outRoundIdx = CNT_W'((N - 1 - int'(cnt)) * UNROLL);
                else
                    outRoundIdx = CNT_W'(int'(cnt) * UNROLL);
                if (cntTerm) nextState = DONE;
            end
            DONE: begin
                outBusy            = 1'b1;
                outIntDataOutRegWr = 1'b1;
                nextState          = HOLD;
            end
            HOLD: begin
                outValid             = 1'b1;
                outIntKeyschRegExtWr = keyReq;
                if (dataReq && inOutReady) begin
                    outIntRoundRegExtWr = 1'b1;
                    cntClr              = 1'b1;
                    modeLoad            = 1'b1;
                    nextState           = (inMode == MODE_DEC) ? KEYFWD : RUN;
                end else if (inOutReady) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase

        // Abort overrides every transition, including back-to-back acceptance.
        if (abortReq && state != IDLE) begin
            nextState           = IDLE;
            cntClr              = 1'b1;
            cntEn               = 1'b0;
            modeLoad            = 1'b0;
            outIntRoundRegExtWr = 1'b0;
            outIntDataOutRegWr  = 1'b0;
        end
    end

endmodule

// File: tb/tb_gift_round_control.sv
// Self-checking bench for gift_round_control: two instances (UNROLL 1 and 4)
// compared every cycle against a cycle-offset reference model.
module tb_gift_round_control;

    localparam int ROUNDS = 40;
    localparam int CW     = 8;
    localparam int NS [2] = '{40, 10};
    localparam int US [2] = '{1, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN, keyWr, dataWr, mode, ready, abortNow;
`ifdef GIFT_ROUND_CONTROL_ABORT_EN
    logic abort;
`endif

    logic [1:0] keyExtW, keyIntW, dirW, roundExtW, roundIntW, dataOutW, modeW, busyW, validW;
    logic [1:0][CW-1:0] idxW;

    gift_round_control #(.ROUNDS(ROUNDS), .UNROLL(1), .CNT_W(CW)) dut1 (
        .inClk(clk), .inRstN(rstN),
`ifdef GIFT_ROUND_CONTROL_ABORT_EN
        .inAbort(abort),
`endif
        .inExtKeyWr(keyWr), .inExtDataWr(dataWr), .inMode(mode), .inOutReady(ready),
        .outIntKeyschRegExtWr(keyExtW[0]), .outIntKeyschRegIntWr(keyIntW[0]),
        .outKeyschDir(dirW[0]), .outIntRoundRegExtWr(roundExtW[0]),
        .outIntRoundRegIntWr(roundIntW[0]), .outIntDataOutRegWr(dataOutW[0]),
        .outRoundIdx(idxW[0]), .outModeLatched(modeW[0]), .outBusy(busyW[0]),
        .outValid(validW[0])
    );

    gift_round_control #(.ROUNDS(ROUNDS), .UNROLL(4), .CNT_W(CW)) dut4 (
        .inClk(clk), .inRstN(rstN),
`ifdef GIFT_ROUND_CONTROL_ABORT_EN
        .inAbort(abort),
`endif
        .inExtKeyWr(keyWr), .inExtDataWr(dataWr), .inMode(mode), .inOutReady(ready),
        .outIntKeyschRegExtWr(keyExtW[1]), .outIntKeyschRegIntWr(keyIntW[1]),
        .outKeyschDir(dirW[1]), .outIntRoundRegExtWr(roundExtW[1]),
        .outIntRoundRegIntWr(roundIntW[1]), .outIntDataOutRegWr(dataOutW[1]),
        .outRoundIdx(idxW[1]), .outModeLatched(modeW[1]), .outBusy(busyW[1]),
        .outValid(validW[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Reference model: a block is described by the cycle it was accepted in and
    // its mode; everything else follows from the cycle offset since acceptance.
    int   cyc = 0;
    int   startCyc [2];
    bit   holding [2];
    logic mMode [2];

    function automatic logic [16:0] obsOf(int i);
        return {keyExtW[i], keyIntW[i], dirW[i], roundExtW[i], roundIntW[i],
                dataOutW[i], idxW[i], modeW[i], busyW[i], validW[i]};
    endfunction

    function automatic logic accOf(int i);
        if (startCyc[i] >= 0) return 1'b0;
        if (holding[i]) return dataWr && ready && !abortNow;
        return dataWr;
    endfunction

    function automatic logic [16:0] expOut(int i);
        int n = NS[i];
        int len = mMode[i] ? 2 * n : n;
        int rel = cyc - startCyc[i];
        int r;
        logic ke = 0, ki = 0, di = 0, re = 0, ri = 0, dw = 0, bz = 0, vl = 0;
        logic [CW-1:0] ix = '0;
        if (startCyc[i] < 0) begin
            ke = keyWr;
            re = accOf(i);
            vl = holding[i];
        end else begin
            bz = 1;
            if (mMode[i] && rel <= n) begin
                ki = 1;
            end else if (rel <= len) begin
                r  = mMode[i] ? rel - n - 1 : rel - 1;
                ri = 1;
                ki = 1;
                di = mMode[i];
                ix = CW'(mMode[i] ? (n - 1 - r) * US[i] : r * US[i]);
            end else begin
                dw = !abortNow;
            end
        end
        return {ke, ki, di, re, ri, dw, ix, mMode[i], bz, vl};
    endfunction

    task automatic modelStep(int i);
        int len = mMode[i] ? 2 * NS[i] : NS[i];
        int rel = cyc - startCyc[i];
        logic acc = accOf(i);
        if (abortNow && (startCyc[i] >= 0 || holding[i])) begin
            startCyc[i] = -1;
            holding[i]  = 0;
        end else if (acc) begin
            startCyc[i] = cyc;
            holding[i]  = 0;
            mMode[i]    = mode;
        end else if (holding[i] && ready) begin
            holding[i] = 0;
        end else if (startCyc[i] >= 0 && rel == len + 1) begin
            holding[i]  = 1;
            startCyc[i] = -1;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            startCyc[i] = -1;
            holding[i]  = 0;
            mMode[i]    = 0;
        end
    endtask

    // Per-block observations used by the latency table and the hand sequences.
    int startAt [2], doneAt [2], firstIdx [2], lastIdx [2], runCnt [2], kfCnt [2], kfDirBad [2];
    bit sawExtStrobe;

    // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic cycle(input logic k, input logic d, input logic m, input logic r,
                         input logic a = 1'b0);
        keyWr = k; dataWr = d; mode = m; ready = r; abortNow = a;
`ifdef GIFT_ROUND_CONTROL_ABORT_EN
        abort = a;
`endif
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d_c%0d", US[i], cyc), 32'(obsOf(i)), 32'(expOut(i)));
            if (roundExtW[i]) begin
                startAt[i] = cyc; doneAt[i] = -1; firstIdx[i] = -1; lastIdx[i] = -1;
                runCnt[i] = 0; kfCnt[i] = 0; kfDirBad[i] = 0;
            end
            if (roundIntW[i]) begin
                if (firstIdx[i] < 0) firstIdx[i] = int'(idxW[i]);
                lastIdx[i] = int'(idxW[i]);
                runCnt[i]++;
            end else if (keyIntW[i]) begin
                kfCnt[i]++;
                if (dirW[i]) kfDirBad[i]++;
            end
            if (dataOutW[i]) doneAt[i] = cyc;
            if (busyW[i] && (roundExtW[i] || keyExtW[i])) sawExtStrobe = 1;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) modelStep(i);
        cyc++;
        #1;
    endtask

    task automatic waitValid(input int budget);
        int t = 0;
        while (validW != 2'b11 && t < budget) begin
            cycle(0, 0, 0, 0);
            t++;
        end
        check("waitValid", 32'(validW), 32'h3);
    endtask

    typedef struct {
        logic mode;
        int   dut;
        int   expDone;
        int   expFirst;
        int   expLast;
        int   expRun;
        int   expKf;
    } blkVec_t;

    blkVec_t vecs [4];

    initial begin
        vecs[0] = '{1'b0, 0, 41,  0, 39, 40,  0};
        vecs[1] = '{1'b1, 0, 81, 39,  0, 40, 40};
        vecs[2] = '{1'b0, 1, 11,  0, 36, 10,  0};
        vecs[3] = '{1'b1, 1, 21, 36,  0, 10, 10};

        modelReset();
        sawExtStrobe = 0;
        rstN = 0; keyWr = 1; dataWr = 1; mode = 0; ready = 0; abortNow = 0;
`ifdef GIFT_ROUND_CONTROL_ABORT_EN
        abort = 0;
`endif
        #3;
        for (int i = 0; i < 2; i++) check($sformatf("rst_u%0d", US[i]), 32'(obsOf(i)), 32'h0);
        keyWr = 0; dataWr = 0;
        #20 rstN = 1;
        @(posedge clk); #1;

        // Latency and round-index order for each mode and unroll factor.
        foreach (vecs[v]) begin
            cycle(0, 1, vecs[v].mode, 0);
            waitValid(200);
            check($sformatf("v%0d_done", v), 32'(doneAt[vecs[v].dut] - startAt[vecs[v].dut]), 32'(vecs[v].expDone));
            check($sformatf("v%0d_first", v), 32'(firstIdx[vecs[v].dut]), 32'(vecs[v].expFirst));
            check($sformatf("v%0d_last", v), 32'(lastIdx[vecs[v].dut]), 32'(vecs[v].expLast));
            check($sformatf("v%0d_run", v), 32'(runCnt[vecs[v].dut]), 32'(vecs[v].expRun));
            check($sformatf("v%0d_kf", v), 32'(kfCnt[vecs[v].dut]), 32'(vecs[v].expKf));
            check($sformatf("v%0d_kfdir", v), 32'(kfDirBad[vecs[v].dut]), 32'h0);
            cycle(0, 0, 0, 1);
        end

        // Load requests during a busy block must be ignored.
        sawExtStrobe = 0;
        cycle(0, 1, 0, 0);
        repeat (5) cycle(0, 0, 0, 0);
        repeat (3) cycle(1, 1, 1, 0);
        waitValid(100);
        check("busy_strobe", 32'(sawExtStrobe), 32'h0);
        check("busy_done", 32'(doneAt[0] - startAt[0]), 32'd41);

        // Result held while the consumer stalls, then back-to-back start.
        for (int t = 0; t < 5; t++) begin
            cycle(0, 0, 0, 0);
            check($sformatf("hold_valid%0d", t), 32'(validW), 32'h3);
            check($sformatf("hold_busy%0d", t), 32'(busyW), 32'h0);
        end
        cycle(0, 1, 0, 1);
        check("b2b_ext", 32'(startAt[0] == cyc - 1 && startAt[1] == cyc - 1), 32'h1);
        check("b2b_valid", 32'(validW), 32'h0);
        check("b2b_busy", 32'(busyW), 32'h3);
        waitValid(100);
        check("b2b_done", 32'(doneAt[0] - startAt[0]), 32'd41);
        cycle(0, 0, 0, 1);

        // Asynchronous reset in the middle of the round phase.
        cycle(0, 1, 0, 0);
        repeat (17) cycle(0, 0, 0, 0);
        check("rst_idx", 32'(idxW[0]), 32'd17);
        keyWr = 1; dataWr = 1;
        #1 rstN = 0;
        #1;
        for (int i = 0; i < 2; i++) check($sformatf("arst_u%0d", US[i]), 32'(obsOf(i)), 32'h0);
        modelReset();
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) check($sformatf("arst2_u%0d", US[i]), 32'(obsOf(i)), 32'h0);
        keyWr = 0; dataWr = 0;
        #2 rstN = 1;
        @(posedge clk); #1;
        cycle(0, 1, 0, 0);
        waitValid(100);
        check("post_rst_u1", 32'(doneAt[0] - startAt[0]), 32'd41);
        check("post_rst_u4", 32'(doneAt[1] - startAt[1]), 32'd11);
        cycle(0, 0, 0, 1);

`ifdef GIFT_ROUND_CONTROL_ABORT_EN
        // Abort during decrypt key-forward at cnt = 3.
        cycle(0, 1, 1, 0);
        repeat (3) cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check("abort_busy", 32'(busyW), 32'h0);
        check("abort_valid", 32'(validW), 32'h0);
        repeat (90) cycle(0, 0, 0, 0);
        check("abort_nodone", 32'(doneAt[0]), 32'hffffffff);
`endif

        // Randomized traffic against the model.
        for (int t = 0; t < 3000; t++) begin
            cycle(($urandom % 4) == 0, ($urandom % 6) == 0, 1'($urandom % 2),
                  ($urandom % 3) != 0,
`ifdef GIFT_ROUND_CONTROL_ABORT_EN
                  ($urandom % 60) == 0
`else
                  1'b0
`endif
            );
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
